// File: rtl/cv32e40p_fault_tracker_ft.sv
// Per-replica leaky error tracker for the TMR ALU/MULT replicas; drives sticky faulty flags.
// Optional FT_FAULT_INJECT_EN adds inject_alu_i/inject_mult_i to force replicas faulty.
module cv32e40p_fault_tracker_ft #(
  parameter int unsigned THRESH    = 4,
  parameter int unsigned CNT_W     = 3,
  parameter int unsigned DECAY_OPS = 256,
  parameter int unsigned DECAY_W   = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ex_valid_i,
  input  logic       alu_used_i,
  input  logic       mult_used_i,
  input  logic [3:0] alu_err_i,
  input  logic [2:0] mult_err_i,
`ifdef FT_FAULT_INJECT_EN
  input  logic [3:0] inject_alu_i,
  input  logic [2:0] inject_mult_i,
`endif
  input  logic       clear_i,
  output logic [3:0] permanent_faulty_alu_o,
  output logic [2:0] permanent_faulty_mult_o,
  output logic       new_fault_o,
  output logic       fault_irq_o
);

  localparam int unsigned NumAlu  = 4;
  localparam int unsigned NumMult = 3;

  localparam logic [1:0] StHealthy = 2'd0;
  localparam logic [1:0] StSuspect = 2'd1;
  localparam logic [1:0] StFaulty  = 2'd2;

  localparam logic [CNT_W-1:0]   CntThresh = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0]   CntOne    = CNT_W'(1);
  localparam logic [DECAY_W-1:0] DecayMax  = DECAY_W'(DECAY_OPS - 1);
  localparam logic [DECAY_W-1:0] DecayOne  = DECAY_W'(1);

  // ALU group state
  logic [1:0]         alu_st_q  [NumAlu];
  logic [1:0]         alu_st_d  [NumAlu];
  logic [CNT_W-1:0]   alu_cnt_q [NumAlu];
  logic [CNT_W-1:0]   alu_cnt_d [NumAlu];
  logic [DECAY_W-1:0] alu_dec_q, alu_dec_d;
  logic [3:0]         alu_flag_q, alu_flag_d;
  logic [3:0]         alu_live, alu_inject;
  logic               alu_sample, alu_decay_step;

  // MULT group state
  logic [1:0]         mult_st_q  [NumMult];
  logic [1:0]         mult_st_d  [NumMult];
  logic [CNT_W-1:0]   mult_cnt_q [NumMult];
  logic [CNT_W-1:0]   mult_cnt_d [NumMult];
  logic [DECAY_W-1:0] mult_dec_q, mult_dec_d;
  logic [2:0]         mult_flag_q, mult_flag_d;
  logic [2:0]         mult_live, mult_inject;
  logic               mult_sample, mult_decay_step;

  logic new_fault_q, new_fault_d;
  logic irq_q, irq_d;

`ifdef FT_FAULT_INJECT_EN
  assign alu_inject  = inject_alu_i;
  assign mult_inject = inject_mult_i;
`else
  assign alu_inject  = '0;
  assign mult_inject = '0;
`endif

  always_comb begin
    for (int i = 0; i < NumAlu; i++) begin
      alu_flag_q[i] = (alu_st_q[i] == StFaulty);
    end
    for (int i = 0; i < NumMult; i++) begin
      mult_flag_q[i] = (mult_st_q[i] == StFaulty);
    end
  end

  // ALU group: errors from FAULTY replicas are masked before counting and decay qualification.
  always_comb begin
    alu_sample     = ex_valid_i & alu_used_i;
    alu_live       = alu_err_i & ~alu_flag_q;
    alu_decay_step = alu_sample && (alu_live == '0) && (alu_dec_q == DecayMax);

    alu_dec_d = alu_dec_q;
    if (alu_sample) begin
      if (alu_live != '0) begin
        alu_dec_d = '0;
      end else if (alu_dec_q == DecayMax) begin
        alu_dec_d = '0;
      end else begin
        alu_dec_d = alu_dec_q + DecayOne;
      end
    end

    for (int i = 0; i < NumAlu; i++) begin
      alu_st_d[i]  = alu_st_q[i];
      alu_cnt_d[i] = alu_cnt_q[i];
      if (alu_sample && alu_live[i]) begin
        if (alu_cnt_q[i] >= (CntThresh - CntOne)) begin
          alu_st_d[i]  = StFaulty;
          alu_cnt_d[i] = CntThresh;
        end else begin
          alu_st_d[i]  = StSuspect;
          alu_cnt_d[i] = alu_cnt_q[i] + CntOne;
        end
      end else if (alu_decay_step && (alu_st_q[i] == StSuspect)) begin
        alu_cnt_d[i] = alu_cnt_q[i] - CntOne;
        alu_st_d[i]  = (alu_cnt_q[i] == CntOne) ? StHealthy : StSuspect;
      end
      if (alu_inject[i]) begin
        alu_st_d[i]  = StFaulty;
        alu_cnt_d[i] = CntThresh;
      end
      if (clear_i) begin
        alu_st_d[i]  = StHealthy;
        alu_cnt_d[i] = '0;
      end
      alu_flag_d[i] = (alu_st_d[i] == StFaulty);
    end

    if (clear_i) begin
      alu_dec_d = '0;
    end
  end

  always_comb begin
    mult_sample     = ex_valid_i & mult_used_i;
    mult_live       = mult_err_i & ~mult_flag_q;
    mult_decay_step = mult_sample && (mult_live == '0) && (mult_dec_q == DecayMax);

    mult_dec_d = mult_dec_q;
    if (mult_sample) begin
      if (mult_live != '0) begin
        mult_dec_d = '0;
      end else if (mult_dec_q == DecayMax) begin
        mult_dec_d = '0;
      end else begin
        mult_dec_d = mult_dec_q + DecayOne;
      end
    end

    for (int i = 0; i < NumMult; i++) begin
      mult_st_d[i]  = mult_st_q[i];
      mult_cnt_d[i] = mult_cnt_q[i];
      if (mult_sample && mult_live[i]) begin
        if (mult_cnt_q[i] >= (CntThresh - CntOne)) begin
          mult_st_d[i]  = StFaulty;
          mult_cnt_d[i] = CntThresh;
        end else begin
          mult_st_d[i]  = StSuspect;
          mult_cnt_d[i] = mult_cnt_q[i] + CntOne;
        end
      end else if (mult_decay_step && (mult_st_q[i] == StSuspect)) begin
        mult_cnt_d[i] = mult_cnt_q[i] - CntOne;
        mult_st_d[i]  = (mult_cnt_q[i] == CntOne) ? StHealthy : StSuspect;
      end
      if (mult_inject[i]) begin
        mult_st_d[i]  = StFaulty;
        mult_cnt_d[i] = CntThresh;
      end
      if (clear_i) begin
        mult_st_d[i]  = StHealthy;
        mult_cnt_d[i] = '0;
      end
      mult_flag_d[i] = (mult_st_d[i] == StFaulty);
    end

    if (clear_i) begin
      mult_dec_d = '0;
    end
  end

  // Pulse and irq are registered from the same edge as the flags so they line up with them.
  always_comb begin
    new_fault_d = 1'b0;
    if (!clear_i) begin
      new_fault_d = (|(alu_flag_d & ~alu_flag_q)) | (|(mult_flag_d & ~mult_flag_q));
    end
    irq_d = (&alu_flag_d) | (&mult_flag_d);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < NumAlu; i++) begin
        alu_st_q[i]  <= StHealthy;
        alu_cnt_q[i] <= '0;
      end
      for (int i = 0; i < NumMult; i++) begin
        mult_st_q[i]  <= StHealthy;
        mult_cnt_q[i] <= '0;
      end
      alu_dec_q   <= '0;
      mult_dec_q  <= '0;
      new_fault_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NumAlu; i++) begin
        alu_st_q[i]  <= alu_st_d[i];
        alu_cnt_q[i] <= alu_cnt_d[i];
      end
      for (int i = 0; i < NumMult; i++) begin
        mult_st_q[i]  <= mult_st_d[i];
        mult_cnt_q[i] <= mult_cnt_d[i];
      end
      alu_dec_q   <= alu_dec_d;
      mult_dec_q  <= mult_dec_d;
      new_fault_q <= new_fault_d;
      irq_q       <= irq_d;
    end
  end

  assign permanent_faulty_alu_o  = alu_flag_q;
  assign permanent_faulty_mult_o = mult_flag_q;
  assign new_fault_o             = new_fault_q;
  assign fault_irq_o             = irq_q;

endmodule

// File: tb/tb_cv32e40p_fault_tracker_ft.sv
// Scoreboard bench for cv32e40p_fault_tracker_ft: stimulus queues expectations, a monitor checks.
module tb_cv32e40p_fault_tracker_ft;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ex_valid = 1'b0;
  logic       alu_used = 1'b0;
  logic       mult_used = 1'b0;
  logic [3:0] alu_err = '0;
  logic [2:0] mult_err = '0;
  logic       clear = 1'b0;
  logic [3:0] pf_alu;
  logic [2:0] pf_mult;
  logic       new_fault;
  logic       fault_irq;

  cv32e40p_fault_tracker_ft dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .ex_valid_i              (ex_valid),
    .alu_used_i              (alu_used),
    .mult_used_i             (mult_used),
    .alu_err_i               (alu_err),
    .mult_err_i              (mult_err),
    .clear_i                 (clear),
    .permanent_faulty_alu_o  (pf_alu),
    .permanent_faulty_mult_o (pf_mult),
    .new_fault_o             (new_fault),
    .fault_irq_o             (fault_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [3:0] fa;
    logic [2:0] fm;
    logic       nf;
    logic       irq;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [3:0] fa, input logic [2:0] fm,
                       input logic nf, input logic irq);
    n_checks++;
    if (pf_alu === fa && pf_mult === fm && new_fault === nf && fault_irq === irq) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got alu=%b mult=%b nf=%b irq=%b, want alu=%b mult=%b nf=%b irq=%b",
               name, pf_alu, pf_mult, new_fault, fault_irq, fa, fm, nf, irq);
    end
  endtask

  // Monitor: outputs settle after each edge; compare every expectation due this cycle.
  always @(posedge clk) begin
    #2;
    cyc++;
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      mon_e = sb.pop_front();
      check(mon_e.name, mon_e.fa, mon_e.fm, mon_e.nf, mon_e.irq);
    end
  end

  task automatic op(input logic v, input logic au, input logic mu, input logic [3:0] ae,
                    input logic [2:0] me, input logic clr);
    @(negedge clk);
    ex_valid  = v;
    alu_used  = au;
    mult_used = mu;
    alu_err   = ae;
    mult_err  = me;
    clear     = clr;
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b0);
  endtask

  task automatic do_clear();
    op(1'b0, 1'b0, 1'b0, 4'b0000, 3'b000, 1'b1);
  endtask

  // Expectation for the outputs right after the edge that samples the op just driven.
  task automatic expect_next(input string name, input logic [3:0] fa, input logic [2:0] fm,
                             input logic nf, input logic irq);
    exp_t e;
    e.tag  = cyc + 1;
    e.fa   = fa;
    e.fm   = fm;
    e.nf   = nf;
    e.irq  = irq;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic alu_ops(input int n, input logic [3:0] ae);
    repeat (n) op(1'b1, 1'b1, 1'b0, ae, 3'b000, 1'b0);
  endtask

  task automatic mult_ops(input int n, input logic [2:0] me);
    repeat (n) op(1'b1, 1'b0, 1'b1, 4'b0000, me, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by 1000000, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check("reset_state", 4'b0000, 3'b000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;

    // Long clean run: decay must never underflow a HEALTHY counter.
    for (int i = 0; i < 300; i++) begin
      alu_ops(1, 4'b0000);
      if (i % 100 == 99) expect_next("clean_run", 4'b0000, 3'b000, 1'b0, 1'b0);
    end

    // Threshold on ALU 2.
    alu_ops(3, 4'b0100);
    expect_next("thresh_minus1", 4'b0000, 3'b000, 1'b0, 1'b0);
    alu_ops(1, 4'b0100);
    expect_next("thresh_hit", 4'b0100, 3'b000, 1'b1, 1'b0);
    idle();
    expect_next("thresh_pulse_end", 4'b0100, 3'b000, 1'b0, 1'b0);
    do_clear();
    expect_next("clear1", 4'b0000, 3'b000, 1'b0, 1'b0);

    // Decay: 3 errors then 256 clean ops leave cnt=2, so 2 more errors are needed.
    mult_ops(3, 3'b010);
    expect_next("mult_cnt3", 4'b0000, 3'b000, 1'b0, 1'b0);
    mult_ops(256, 3'b000);
    mult_ops(1, 3'b010);
    expect_next("decay_to2_then_3", 4'b0000, 3'b000, 1'b0, 1'b0);
    mult_ops(1, 3'b010);
    expect_next("decay_to2_then_4", 4'b0000, 3'b010, 1'b1, 1'b0);
    do_clear();
    expect_next("clear2", 4'b0000, 3'b000, 1'b0, 1'b0);

    // Full decay back to HEALTHY: 4 fresh errors needed again.
    mult_ops(3, 3'b010);
    mult_ops(1024, 3'b000);
    expect_next("decay_full", 4'b0000, 3'b000, 1'b0, 1'b0);
    mult_ops(3, 3'b010);
    expect_next("healthy_again_3", 4'b0000, 3'b000, 1'b0, 1'b0);
    mult_ops(1, 3'b010);
    expect_next("healthy_again_4", 4'b0000, 3'b010, 1'b1, 1'b0);
    do_clear();
    expect_next("clear3", 4'b0000, 3'b000, 1'b0, 1'b0);

    // Masking and irq.
    alu_ops(4, 4'b0111);
    expect_next("alu012_faulty", 4'b0111, 3'b000, 1'b1, 1'b0);
    alu_ops(10, 4'b0111);
    expect_next("masked_errs", 4'b0111, 3'b000, 1'b0, 1'b0);
    alu_ops(3, 4'b1000);
    expect_next("alu3_cnt3", 4'b0111, 3'b000, 1'b0, 1'b0);
    alu_ops(1, 4'b1000);
    expect_next("alu_irq", 4'b1111, 3'b000, 1'b1, 1'b1);
    idle();
    expect_next("alu_irq_hold", 4'b1111, 3'b000, 1'b0, 1'b1);
    do_clear();
    expect_next("clear4", 4'b0000, 3'b000, 1'b0, 1'b0);
    mult_ops(4, 3'b111);
    expect_next("mult_irq", 4'b0000, 3'b111, 1'b1, 1'b1);
    do_clear();
    expect_next("clear5", 4'b0000, 3'b000, 1'b0, 1'b0);

    // Simultaneous flags, then the same with clear winning.
    alu_ops(3, 4'b1001);
    alu_ops(1, 4'b1001);
    expect_next("simul_flags", 4'b1001, 3'b000, 1'b1, 1'b0);
    idle();
    expect_next("simul_single_pulse", 4'b1001, 3'b000, 1'b0, 1'b0);
    do_clear();
    alu_ops(3, 4'b1001);
    op(1'b1, 1'b1, 1'b0, 4'b1001, 3'b000, 1'b1);
    expect_next("clear_wins", 4'b0000, 3'b000, 1'b0, 1'b0);
    alu_ops(1, 4'b1001);
    expect_next("after_clear_cnt1", 4'b0000, 3'b000, 1'b0, 1'b0);
    do_clear();

    // Both groups sampling in one op, and gating by ex_valid / alu_used.
    repeat (4) op(1'b1, 1'b1, 1'b1, 4'b0001, 3'b001, 1'b0);
    expect_next("both_groups", 4'b0001, 3'b001, 1'b1, 1'b0);
    do_clear();
    repeat (4) op(1'b0, 1'b1, 1'b1, 4'b1111, 3'b111, 1'b0);
    expect_next("no_valid", 4'b0000, 3'b000, 1'b0, 1'b0);
    repeat (4) op(1'b1, 1'b0, 1'b1, 4'b1111, 3'b000, 1'b0);
    expect_next("alu_unused", 4'b0000, 3'b000, 1'b0, 1'b0);

    // Async reset between edges with ALU1 faulty and ALU2 at cnt=2.
    alu_ops(2, 4'b0110);
    alu_ops(2, 4'b0010);
    expect_next("pre_async", 4'b0010, 3'b000, 1'b1, 1'b0);
    idle();
    #2;
    rst_n = 1'b1;
    #1;
    check("async_rst", 4'b0000, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    alu_ops(2, 4'b0100);
    expect_next("async_cnt_cleared", 4'b0000, 3'b000, 1'b0, 1'b0);
    alu_ops(2, 4'b0100);
    expect_next("async_refault", 4'b0100, 3'b000, 1'b1, 1'b0);

    repeat (3) idle();
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cv32e40p_fault_tracker_ft.md
Name: cv32e40p_fault_tracker_ft

Overview:
- Sits directly upstream of the ALU/MULT replica dispatcher.
- Takes per-replica mismatch reports from the EX-stage TMR voters and keeps a leaky saturating error count per replica.
- Promotes a replica to "permanently faulty" once its count reaches a threshold.
- Drives the sticky permanent_faulty vectors that the dispatcher decodes into clock gating, mux and bypass selects.

Parameters:
THRESH, 4, mismatch count at which a replica becomes permanently faulty; legal range 1..2^CNT_W-1
CNT_W, 3, width of each per-replica error counter
DECAY_OPS, 256, error-free qualifying operations per decay step; legal range 2..2^DECAY_W
DECAY_W, 9, width of the ALU and MULT decay counters

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous reset, active-HIGH: state is held in reset while rst_n=1
ex_valid_i  in  1  an EX-stage operation completes this cycle and voter outputs are valid
alu_used_i  in  1  the completing operation used the ALU replicas
mult_used_i  in  1  the completing operation used the MULT replicas
alu_err_i  in  4  per-ALU voter mismatch, bit i = ALU i disagreed with the majority
mult_err_i  in  3  per-MULT voter mismatch
clear_i  in  1  synchronous clear of all counters and flags (CSR write)
permanent_faulty_alu_o  out  4  sticky faulty flags to the dispatcher
permanent_faulty_mult_o  out  3  sticky faulty flags to the dispatcher
new_fault_o  out  1  one-cycle pulse: at least one flag newly set this cycle
fault_irq_o  out  1  level: all 4 ALUs or all 3 MULTs are faulty

Behaviour:
- Reset (rst_n=1, asynchronous):
  - all counters = 0, all flags = 0, all per-replica states HEALTHY;
  - all outputs = 0.
- Per-replica FSM, one instance per ALU (4) and per MULT (3):
  - States: HEALTHY (cnt=0), SUSPECT (0<cnt<THRESH), FAULTY (sticky, cnt held at THRESH).
  - ALU sample condition: ex_valid_i && alu_used_i. MULT sample condition: ex_valid_i && mult_used_i.
  - If both alu_used_i and mult_used_i are set, both groups sample.
- Increment:
  - On a sample with err bit i=1 and replica i not FAULTY: cnt_i += 1.
  - If the new cnt_i >= THRESH, the replica enters FAULTY at the same edge. The flag is therefore visible the cycle after the erroneous op.
  - Err bits of FAULTY replicas are ignored.
  - Multiple replicas may increment in the same cycle.
- Decay (per group):
  - The decay counter increments on each sample whose err vector, masked by non-FAULTY replicas, is all zero.
  - When it reaches DECAY_OPS-1 and increments, it wraps to 0. On that same edge every SUSPECT replica in the group decrements by 1; a replica reaching cnt=0 returns to HEALTHY.
  - A sample with any unmasked error resets the group decay counter to 0.
  - An error and a decay step cannot coincide on the same replica: the error wins, and the decay step is not taken.
- Flags:
  - permanent_faulty_*_o[i] = (state_i == FAULTY), registered.
  - Flags are never cleared except by reset or clear_i.
- new_fault_o: registered pulse, high for exactly one cycle after any 0->1 flag transition. Simultaneous transitions give a single pulse.
- fault_irq_o: registered level, equal to (&permanent_faulty_alu_o) | (&permanent_faulty_mult_o).
- clear_i:
  - Synchronous: next state is identical to reset.
  - Has priority over a same-cycle sample.
  - new_fault_o is low on the cycle following a clear.
- No sampling when ex_valid_i=0. err inputs are don't-care then.
- Latency summary:
  - error sample to flag: 1 cycle;
  - flag to new_fault_o: same cycle (both registered from the same edge);
  - fault_irq_o: same cycle as the completing flag.

Optional Feature:
FT_FAULT_INJECT_EN
- Defined:
  - Adds inputs inject_alu_i[3:0] and inject_mult_i[2:0].
  - A 1 on a bit forces that replica to FAULTY at the next edge, regardless of count, and pulses new_fault_o.
  - clear_i still has priority over injection.
- Undefined: the ports and logic are absent; faulty flags arise only from counted mismatches.

Test Plan:
1. Reset: rst_n=1 then 0; 300 error-free ALU ops -> all outputs stay 0 and decay never underflows.
2. Threshold: 4 samples with alu_err_i=4'b0100 (THRESH=4) -> permanent_faulty_alu_o=4'b0100 one cycle after the 4th sample, new_fault_o pulses once.
3. Decay: 3 errors on MULT 1, then 256 clean MULT ops -> cnt drops to 2. After 768 more clean ops it reaches 0 and the replica is HEALTHY. A 4th error after that does not set the flag.
4. Masking and irq: ALU 0,1,2 already faulty; alu_err_i=4'b0111 for 10 ops -> no change. 4 errors on ALU 3 -> flags=4'b1111, fault_irq_o=1.
5. Simultaneous events: the same sample has alu_err_i=4'b1001 with both counts at 3, and clear_i=0 -> both flags set, a single new_fault_o pulse. Repeat with clear_i=1 -> all 0, no pulse.
6. Async reset mid-operation: rst_n pulsed high between clock edges while cnt=2 -> counters and flags are 0 immediately, without a clock edge.
